// File: rtl/uart_rx_mmio_if.sv
// uart_rx_mmio_if
// CPU data-bus bundle for the memory-mapped UART receiver.
//   MemRead    : read strobe, held for one whole CPU cycle
//   MemWrite   : write strobe, held for one whole CPU cycle
//   Address    : byte address
//   Write_data : store data
//   Read_data  : load data, driven combinationally by the selected responder
// master = CPU side, slave = peripheral side.
interface uart_rx_mmio_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;

  modport master (
    output MemRead, MemWrite, Address, Write_data,
    input  Read_data
  );

  modport slave (
    input  MemRead, MemWrite, Address, Write_data,
    output Read_data
  );
endinterface

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio
// Memory-mapped UART receiver. Deserialises 8N1 frames (8E1 when the
// UART_RX_PARITY_EN macro is defined) from uart_rx into a byte FIFO and
// exposes it through three word registers:
//   BASE_ADDR+0 RXDATA : read pops the head byte (0 when empty), writes ignored
//   BASE_ADDR+4 STATUS : [0] ~empty [1] full [2] overrun [3] frame_err
//                        [4] parity_err [15:8] count; W1C on [4:2]
//   BASE_ADDR+8 CTRL   : [0] irq_en
// Ports:
//   reset   : asynchronous, active-low reset
//   clk     : system clock
//   bus     : CPU data bus (slave modport of uart_rx_mmio_if)
//   uart_rx : asynchronous serial input, idle high
//   irqout  : registered level interrupt, irq_en & ~empty
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after data).
module uart_rx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h40000020,
  parameter int          CLKS_PER_BIT = 5208,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic          reset,
  input  logic          clk,
  uart_rx_mmio_if.slave bus,
  input  logic          uart_rx,
  output logic          irqout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [7:0]       shift, shift_next;
  logic [2:0]       bit_idx, bit_next;
  logic             rx_meta, rx_sync;
  logic             push, frame_set;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             empty, full, pop, push_ok, overrun_set;
  logic             overrun, frame_err, parity_err, irq_en;

  logic [29:0]      word_addr;
  logic             sel_data, sel_status, sel_ctrl, status_wr;
  logic             unused_ok;

`ifdef UART_RX_PARITY_EN
  logic par_bad, par_bad_next, parity_set;
`endif

  // Two-flop synchroniser; resets to the idle-high line level so a reset
  // never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // Receiver state and datapath registers; a reset mid-frame simply
  // returns to IDLE and the partial shift register is never pushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      shift   <= '0;
      bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      shift   <= shift_next;
      bit_idx <= bit_next;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_next;
`endif
    end
  end

  // Next-state logic. The half-bit wait in START lands every later sample
  // near the centre of its bit; each sample then reloads a full bit time.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shift_next = shift;
    bit_next   = bit_idx;
    push       = 1'b0;
    frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next = par_bad;
    parity_set   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_sync) begin
          cnt_next   = HALF_BIT;
          state_next = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (!rx_sync) begin
            state_next = DATA;
            cnt_next   = FULL_BIT;
            bit_next   = 3'd0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shift_next = {rx_sync, shift[7:1]};
          cnt_next   = FULL_BIT;
          bit_next   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == '0) begin
          par_bad_next = ^{shift, rx_sync};
          cnt_next     = FULL_BIT;
          state_next   = STOP;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == '0) begin
          state_next = IDLE;
          frame_set  = ~rx_sync;
`ifdef UART_RX_PARITY_EN
          parity_set = par_bad;
          push       = rx_sync & ~par_bad;
`else
          push       = rx_sync;
`endif
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Word-granular decode; Address[1:0] are ignored.
  assign word_addr  = bus.Address[31:2];
  assign sel_data   = (word_addr == BASE_ADDR[31:2]);
  assign sel_status = (word_addr == BASE_ADDR[31:2] + 30'd1);
  assign sel_ctrl   = (word_addr == BASE_ADDR[31:2] + 30'd2);
  assign status_wr  = bus.MemWrite & sel_status;

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_CNT);
  assign pop         = bus.MemRead & sel_data & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO survives.
  assign push_ok     = push & (~full | pop);
  assign overrun_set = push & full & ~pop;

  // FIFO storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shift;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags with W1C; a set event in the clear cycle wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      irq_en    <= 1'b0;
      irqout    <= 1'b0;
    end else begin
      overrun   <= overrun_set | (overrun & ~(status_wr & bus.Write_data[2]));
      frame_err <= frame_set | (frame_err & ~(status_wr & bus.Write_data[3]));
      if (bus.MemWrite && sel_ctrl) irq_en <= bus.Write_data[0];
      irqout    <= irq_en & ~empty;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error flag, same sticky W1C behaviour as the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= parity_set | (parity_err & ~(status_wr & bus.Write_data[4]));
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // Combinational load data; zero whenever this block is not being read.
  always_comb begin
    bus.Read_data = '0;
    if (bus.MemRead) begin
      if (sel_data && !empty) begin
        bus.Read_data = {24'b0, mem[rd_ptr]};
      end else if (sel_status) begin
        bus.Read_data = {16'b0, 8'(count), 3'b0, parity_err, frame_err,
                         overrun, full, ~empty};
      end else if (sel_ctrl) begin
        bus.Read_data = {31'b0, irq_en};
      end
    end
  end

  assign unused_ok = &{1'b0, bus.Address[1:0], bus.Write_data};

endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb_uart_rx_mmio
// Directed self-checking bench for uart_rx_mmio with CLKS_PER_BIT=16 and
// FIFO_DEPTH=8. Serial frames are driven bit by bit on uart_rx; registers
// are accessed through one-cycle lw/sw bus transactions.
module tb_uart_rx_mmio;

  localparam int          CPB    = 16;
  localparam logic [31:0] RXDATA = 32'h40000020;
  localparam logic [31:0] STATUS = 32'h40000024;
  localparam logic [31:0] CTRL   = 32'h40000028;

  logic clk;
  logic reset;
  logic uart_rx;
  logic irqout;
  logic [31:0] rd;
  int num_checks;
  int num_failures;

  uart_rx_mmio_if bus_if ();

  uart_rx_mmio #(
    .BASE_ADDR   (32'h40000020),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (8)
  ) dut (
    .reset  (reset),
    .clk    (clk),
    .bus    (bus_if.slave),
    .uart_rx(uart_rx),
    .irqout (irqout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Holds the line at one level for a full bit time, driving just after posedge.
  task automatic holdBit(input logic v);
    uart_rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Sends one serial frame then leaves the line idle long enough to settle.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input logic bad_parity);
    @(posedge clk);
    #1;
    holdBit(1'b0);
    for (int i = 0; i < 8; i++) holdBit(data[i]);
`ifdef UART_RX_PARITY_EN
    holdBit((^data) ^ bad_parity);
`else
    if (bad_parity) $display("[TB] note: parity request ignored in 8N1 build");
`endif
    holdBit(stop_bit);
    uart_rx = 1'b1;
    repeat (40) @(posedge clk);
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus_if.Address = addr;
    bus_if.MemRead = 1'b1;
    #2;
    data = bus_if.Read_data;
    @(negedge clk);
    bus_if.MemRead = 1'b0;
    bus_if.Address = '0;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_if.Address    = addr;
    bus_if.Write_data = data;
    bus_if.MemWrite   = 1'b1;
    @(negedge clk);
    bus_if.MemWrite   = 1'b0;
    bus_if.Address    = '0;
    bus_if.Write_data = '0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    num_checks   = 0;
    num_failures = 0;
    reset        = 1'b0;
    uart_rx      = 1'b1;
    bus_if.MemRead    = 1'b0;
    bus_if.MemWrite   = 1'b0;
    bus_if.Address    = '0;
    bus_if.Write_data = '0;

    // Reset state, checked while reset is still held and after release.
    repeat (3) @(posedge clk);
    busRead(STATUS, rd);
    checkOutput("status_in_reset", rd, 32'h0);
    checkOutput("irq_in_reset", {31'b0, irqout}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    busRead(RXDATA, rd); checkOutput("rxdata_idle", rd, 32'h0);
    busRead(STATUS, rd); checkOutput("status_idle", rd, 32'h0);
    busRead(CTRL, rd);   checkOutput("ctrl_idle", rd, 32'h0);
    busRead(32'h4000002C, rd); checkOutput("unmapped_2c", rd, 32'h0);
    busRead(32'h40000010, rd); checkOutput("unmapped_10", rd, 32'h0);
    checkOutput("irq_idle", {31'b0, irqout}, 32'h0);

    // Single byte round trip.
    applyStimulus(8'hA5, 1'b1, 1'b0);
    busRead(STATUS, rd); checkOutput("status_a5", rd, 32'h0000_0101);
    busRead(RXDATA, rd); checkOutput("rxdata_a5", rd, 32'h0000_00A5);
    busRead(STATUS, rd); checkOutput("status_after_pop", rd, 32'h0);
    busRead(RXDATA, rd); checkOutput("rxdata_empty", rd, 32'h0);
    busRead(STATUS, rd); checkOutput("status_empty_read", rd, 32'h0);

    // Nine bytes into an eight-deep FIFO: last byte dropped, overrun set.
    for (int i = 0; i < 9; i++) applyStimulus(8'h10 + 8'(i), 1'b1, 1'b0);
    busRead(STATUS, rd); checkOutput("status_full", rd, 32'h0000_0807);
    checkOutput("irq_disabled", {31'b0, irqout}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      busRead(RXDATA, rd);
      checkOutput($sformatf("fifo_order_%0d", i), rd, 32'h10 + 32'(i));
    end
    busRead(STATUS, rd); checkOutput("status_drained", rd, 32'h0000_0004);
    busWrite(STATUS, 32'h4);
    busRead(STATUS, rd); checkOutput("overrun_w1c", rd, 32'h0);

    // Stop bit held low: frame error, byte dropped, receiver recovers.
    applyStimulus(8'h3C, 1'b0, 1'b0);
    busRead(STATUS, rd); checkOutput("frame_err", rd, 32'h0000_0008);
    busWrite(STATUS, 32'h8);
    busRead(STATUS, rd); checkOutput("frame_err_w1c", rd, 32'h0);
    applyStimulus(8'h11, 1'b1, 1'b0);
    busRead(STATUS, rd); checkOutput("status_11", rd, 32'h0000_0101);
    busRead(RXDATA, rd); checkOutput("rxdata_11", rd, 32'h0000_0011);

    // Short low glitch must be rejected as a false start.
    @(posedge clk); #1;
    uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (60) @(posedge clk);
    busRead(STATUS, rd); checkOutput("glitch_status", rd, 32'h0);

    // Interrupt enable and level behaviour.
    busWrite(CTRL, 32'hFFFF_FFFF);
    busRead(CTRL, rd); checkOutput("ctrl_readback", rd, 32'h1);
    checkOutput("irq_enabled_empty", {31'b0, irqout}, 32'h0);
    applyStimulus(8'h55, 1'b1, 1'b0);
    checkOutput("irq_raised", {31'b0, irqout}, 32'h1);
    busRead(RXDATA, rd); checkOutput("rxdata_55", rd, 32'h0000_0055);
    checkOutput("irq_still_registered", {31'b0, irqout}, 32'h1);
    @(negedge clk);
    checkOutput("irq_fell", {31'b0, irqout}, 32'h0);

`ifdef UART_RX_PARITY_EN
    // Wrong parity: byte dropped, parity_err set, then cleared by W1C.
    applyStimulus(8'h55, 1'b1, 1'b1);
    busRead(STATUS, rd); checkOutput("parity_err", rd, 32'h0000_0010);
    busWrite(STATUS, 32'h10);
    busRead(STATUS, rd); checkOutput("parity_err_w1c", rd, 32'h0);
`endif

    // Reset asserted mid-frame aborts the byte and clears irq_en.
    @(posedge clk); #1;
    uart_rx = 1'b0;
    repeat (CPB * 3) @(posedge clk);
    #1;
    reset   = 1'b0;
    uart_rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (CPB * 12) @(posedge clk);
    busRead(STATUS, rd); checkOutput("midframe_reset_status", rd, 32'h0);
    busRead(CTRL, rd);   checkOutput("midframe_reset_ctrl", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
    $finish;
  end

endmodule
